// File: rtl/sine_pkg.sv
//------------------------------------------------------------------------------
// Module      : sine_pkg
// Description : Shared widths, quarter-wave sine table and FSM encoding for
//               the sine phase search block.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sine_pkg;

    localparam int WIDTH_D = 8;
    localparam int WIDTH_A = 5;
    localparam int DEPTH   = 1 << WIDTH_A;

    localparam logic [WIDTH_D-1:0] SINE_TABLE [0:DEPTH-1] = '{
        8'd3,   8'd9,   8'd16,  8'd22,  8'd28,  8'd34,  8'd40,  8'd46,
        8'd51,  8'd57,  8'd63,  8'd68,  8'd73,  8'd78,  8'd83,  8'd88,
        8'd92,  8'd96,  8'd100, 8'd104, 8'd107, 8'd111, 8'd113, 8'd116,
        8'd118, 8'd121, 8'd122, 8'd124, 8'd125, 8'd126, 8'd127, 8'd127
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    function automatic logic [WIDTH_D-1:0] sine_lut(input logic [WIDTH_A-1:0] idx);
        return SINE_TABLE[idx];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sine_quarter_rom.sv
//------------------------------------------------------------------------------
// Module      : sine_quarter_rom
// Description : Combinational read of the 32-entry quarter-wave sine table.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sine_quarter_rom
    import sine_pkg::*;
(
    input  logic [WIDTH_A-1:0] addr_i,
    output logic [WIDTH_D-1:0] data_o
);

    assign data_o = SINE_TABLE[addr_i];

endmodule

`default_nettype wire

// File: rtl/sine_phase_search.sv
//------------------------------------------------------------------------------
// Module      : sine_phase_search
// Description : Fixed-latency 5-step binary search returning the smallest
//               quarter-wave phase whose table value covers |sample|.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sine_phase_search
    import sine_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_D-1:0] in_sample,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_A-1:0] out_phase,
    output logic               out_neg,
    output logic               out_exact
);

    localparam logic [1:0]         ST_IDLE   = IDLE;
    localparam logic [1:0]         ST_SEARCH = SEARCH;
    localparam logic [1:0]         ST_DONE   = DONE;
    localparam logic [2:0]         LAST_ITER = 3'd4;
    localparam logic [WIDTH_A-1:0] MAX_IDX   = WIDTH_A'(DEPTH - 1);

    logic [1:0]         state_q,     state_d;
    logic [WIDTH_A-1:0] lo_q,        lo_d;
    logic [WIDTH_A-1:0] hi_q,        hi_d;
    logic [2:0]         cnt_q,       cnt_d;
    logic [WIDTH_D-1:0] target_q,    target_d;
    logic               neg_q,       neg_d;
    logic               clamp_q,     clamp_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH_A-1:0] out_phase_q, out_phase_d;
    logic               out_neg_q,   out_neg_d;
    logic               out_exact_q, out_exact_d;

    logic [WIDTH_A:0]   w_sum;
    logic [WIDTH_A-1:0] w_mid;
    logic [WIDTH_D-1:0] w_probe;
    logic               w_is_min;
    logic [WIDTH_D-1:0] w_mag;

    // 6-bit sum keeps lo+hi from wrapping before the halving shift
    assign w_sum = {1'b0, lo_q} + {1'b0, hi_q};
    assign w_mid = w_sum[WIDTH_A:1];

    sine_quarter_rom u_rom (
        .addr_i (w_mid),
        .data_o (w_probe)
    );

    // -128 has no positive counterpart in 8 bits, so it saturates to 127
    assign w_is_min = (in_sample == {1'b1, {(WIDTH_D-1){1'b0}}});
    assign w_mag    = w_is_min     ? 8'd127 :
                      in_sample[7] ? WIDTH_D'(-in_sample) : in_sample;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_phase = out_phase_q;
    assign out_neg   = out_neg_q;
    assign out_exact = out_exact_q;

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        cnt_d       = cnt_q;
        target_d    = target_q;
        neg_d       = neg_q;
        clamp_d     = clamp_q;
        out_valid_d = out_valid_q;
        out_phase_d = out_phase_q;
        out_neg_d   = out_neg_q;
        out_exact_d = out_exact_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d  = ST_SEARCH;
                    target_d = w_mag;
                    neg_d    = in_sample[WIDTH_D-1];
                    clamp_d  = w_is_min;
                    lo_d     = '0;
                    hi_d     = MAX_IDX;
                    cnt_d    = '0;
                end
            end
            ST_SEARCH: begin
                if (lo_q != hi_q) begin
                    if (w_probe >= target_q) begin
                        hi_d = w_mid;
                    end else begin
                        lo_d = w_mid + 1'b1;
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_phase_d = (target_q > SINE_TABLE[DEPTH-1]) ? MAX_IDX : lo_d;
                    out_neg_d   = neg_q;
                    out_exact_d = (sine_lut(lo_d) == target_q) && !clamp_q;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            cnt_q       <= '0;
            target_q    <= '0;
            neg_q       <= 1'b0;
            clamp_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_phase_q <= '0;
            out_neg_q   <= 1'b0;
            out_exact_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            neg_q       <= neg_d;
            clamp_q     <= clamp_d;
            out_valid_q <= out_valid_d;
            out_phase_q <= out_phase_d;
            out_neg_q   <= out_neg_d;
            out_exact_q <= out_exact_d;
        end
    end

endmodule

`default_nettype wire
